// File: rtl/keycode_action_map_if.sv
// Key report in, registered game actions out, between the HID keycode register and game logic.
interface keycode_action_map_if #(
  parameter int SLOTS = 4
);
  logic [8*SLOTS-1:0] keycode;
  logic [1:0]         move;
  logic               jump;
  logic               jump_pulse;
  logic               shoot;
  logic               restart;
  logic               god;
  logic [3:0]         seq_progress;

  modport master (
    output keycode,
    input  move, jump, jump_pulse, shoot, restart, god, seq_progress
  );

  modport slave (
    input  keycode,
    output move, jump, jump_pulse, shoot, restart, god, seq_progress
  );
endinterface

// File: rtl/keycode_action_map.sv
// Decodes a report of SLOTS keycodes into movement, jump, auto-repeat shoot, restart and a
// sequence-unlocked god latch; every output reflects the report sampled on the previous Clk edge.
module keycode_action_map #(
  parameter int          SLOTS         = 4,
  parameter int          SEQ_LEN       = 5,
  parameter logic [63:0] SEQ_CODES     = 64'h0F_04_11_0C_09,
  parameter int          REPEAT_PERIOD = 8,
  parameter logic [7:0]  KEY_LEFT      = 8'h04,
  parameter logic [7:0]  KEY_RIGHT     = 8'h07,
  parameter logic [7:0]  KEY_JUMP      = 8'h1A,
  parameter logic [7:0]  KEY_SHOOT     = 8'h0D,
  parameter logic [7:0]  KEY_RESTART   = 8'h15,
  parameter logic [7:0]  KEY_CLEAR     = 8'h29
) (
  input logic                 Clk,
  input logic                 Reset,
  keycode_action_map_if.slave bus
);
  typedef enum logic {S_IDLE, S_MATCH} seq_state_t;

  localparam logic [7:0] RPT_LAST  = 8'(REPEAT_PERIOD - 1);
  localparam logic [3:0] SEQ_LAST  = 4'(SEQ_LEN - 1);
  localparam logic [7:0] SEQ_FIRST = SEQ_CODES[7:0];

  function automatic logic has_code(input logic [8*SLOTS-1:0] rpt, input logic [7:0] k);
    logic hit;
    hit = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (k != 8'h00 && rpt[8*s +: 8] == k) hit = 1'b1;
    end
    return hit;
  endfunction

  logic [8*SLOTS-1:0] r_prev;
  logic               r_last_right;
  logic [7:0]         r_rpt_cnt;
  logic [1:0]         r_move;
  logic               r_jump, r_jump_pulse, r_shoot, r_restart, r_god;
  seq_state_t         r_state, w_state_nxt;
  logic [3:0]         r_idx, w_idx_nxt;

  logic       w_left, w_right, w_new_left, w_new_right;
  logic       w_jump, w_new_jump, w_shoot_held, w_new_shoot;
  logic       w_restart, w_clear, w_new_any;
  logic [1:0] w_move_nxt;
  logic       w_last_right_nxt;
  logic       w_shoot_nxt;
  logic [7:0] w_rpt_nxt;
  logic [7:0] w_step_code;
  logic       w_step_new, w_first_new, w_unlock;

  assign w_left       = has_code(bus.keycode, KEY_LEFT);
  assign w_right      = has_code(bus.keycode, KEY_RIGHT);
  assign w_new_left   = w_left & ~has_code(r_prev, KEY_LEFT);
  assign w_new_right  = w_right & ~has_code(r_prev, KEY_RIGHT);
  assign w_jump       = has_code(bus.keycode, KEY_JUMP);
  assign w_new_jump   = w_jump & ~has_code(r_prev, KEY_JUMP);
  assign w_shoot_held = has_code(bus.keycode, KEY_SHOOT);
  assign w_new_shoot  = w_shoot_held & ~has_code(r_prev, KEY_SHOOT);
  assign w_restart    = has_code(bus.keycode, KEY_RESTART);
  assign w_clear      = has_code(bus.keycode, KEY_CLEAR);

  always_comb begin
    w_new_any = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (bus.keycode[8*s +: 8] != 8'h00 && !has_code(r_prev, bus.keycode[8*s +: 8]))
        w_new_any = 1'b1;
    end
  end

  // With both keys held, the freshest press wins; a tie keeps the current direction.
  always_comb begin
    w_move_nxt       = 2'b00;
    w_last_right_nxt = r_last_right;
    if (w_right && !w_left) begin
      w_move_nxt = 2'b01;
    end else if (w_left && !w_right) begin
      w_move_nxt = 2'b10;
    end else if (w_left && w_right) begin
      if (w_new_left && !w_new_right)      w_move_nxt = 2'b10;
      else if (w_new_right && !w_new_left) w_move_nxt = 2'b01;
      else if (w_new_left && w_new_right)  w_move_nxt = (r_move == 2'b00) ? 2'b01 : r_move;
      else                                 w_move_nxt = r_last_right ? 2'b01 : 2'b10;
    end
    if (w_new_left && !w_new_right)      w_last_right_nxt = 1'b0;
    else if (w_new_right && !w_new_left) w_last_right_nxt = 1'b1;
    else if (w_new_left && w_new_right)  w_last_right_nxt = (w_move_nxt == 2'b01);
  end

  always_comb begin
    w_shoot_nxt = 1'b0;
    w_rpt_nxt   = 8'd0;
    if (w_new_shoot) begin
      w_shoot_nxt = 1'b1;
    end else if (w_shoot_held) begin
      if (r_rpt_cnt == RPT_LAST) w_shoot_nxt = 1'b1;
      else                       w_rpt_nxt   = r_rpt_cnt + 8'd1;
    end
  end

  // Only fresh presses advance or break the sequence, so holds and releases are neutral.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_unlock    = 1'b0;
    w_step_code = SEQ_CODES[{r_idx[2:0], 3'b000} +: 8];
    w_step_new  = has_code(bus.keycode, w_step_code) & ~has_code(r_prev, w_step_code);
    w_first_new = has_code(bus.keycode, SEQ_FIRST) & ~has_code(r_prev, SEQ_FIRST);
    if (w_clear) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 4'd0;
    end else if (w_new_any) begin
      if (w_step_new) begin
        if (r_idx == SEQ_LAST) begin
          w_unlock    = 1'b1;
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 4'd0;
        end else begin
          w_state_nxt = S_MATCH;
          w_idx_nxt   = r_idx + 4'd1;
        end
      end else if (w_first_new) begin
        if (SEQ_LEN == 1) begin
          w_unlock    = 1'b1;
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 4'd0;
        end else begin
          w_state_nxt = S_MATCH;
          w_idx_nxt   = 4'd1;
        end
      end else begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 4'd0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prev       <= '0;
      r_last_right <= 1'b1;
      r_rpt_cnt    <= 8'd0;
      r_move       <= 2'b00;
      r_jump       <= 1'b0;
      r_jump_pulse <= 1'b0;
      r_shoot      <= 1'b0;
      r_restart    <= 1'b0;
      r_god        <= 1'b0;
    end else begin
      r_prev       <= bus.keycode;
      r_last_right <= w_last_right_nxt;
      r_rpt_cnt    <= w_rpt_nxt;
      r_move       <= w_move_nxt;
      r_jump       <= w_jump;
      r_jump_pulse <= w_new_jump;
      r_shoot      <= w_shoot_nxt;
      r_restart    <= w_restart;
      if (w_clear)       r_god <= 1'b0;
      else if (w_unlock) r_god <= 1'b1;
    end
  end

  assign bus.move         = r_move;
  assign bus.jump         = r_jump;
  assign bus.jump_pulse   = r_jump_pulse;
  assign bus.shoot        = r_shoot;
  assign bus.restart      = r_restart;
  assign bus.god          = r_god;
  assign bus.seq_progress = r_idx;
endmodule

// File: tb/tb_keycode_action_map.sv
// Table-driven and sequence checks of keycode_action_map through a one-cycle scoreboard queue.
module tb_keycode_action_map;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  keycode_action_map_if #(.SLOTS(4)) bus ();

  keycode_action_map dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] mv;
    logic       jp;
    logic       jpl;
    logic       sh;
    logic       rs;
    logic       gd;
    logic [3:0] pg;
  } out_t;

  typedef struct {
    logic [31:0] kc;
    out_t        exp;
  } vec_t;

  out_t exp_q[$];
  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic out_t o(input logic [1:0] mv, input logic jp, input logic jpl,
                             input logic sh, input logic rs, input logic gd,
                             input logic [3:0] pg);
    out_t r;
    r.mv = mv; r.jp = jp; r.jpl = jpl; r.sh = sh; r.rs = rs; r.gd = gd; r.pg = pg;
    return r;
  endfunction

  // Drive one report, queue its expectation, and compare once the registered outputs settle.
  task automatic step(input logic rst, input logic [31:0] kc, input out_t e, input string name);
    out_t got, want;
    @(negedge Clk);
    Reset       = rst;
    bus.keycode = kc;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    got  = {bus.move, bus.jump, bus.jump_pulse, bus.shoot, bus.restart, bus.god, bus.seq_progress};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got mv=%b jp=%b jpl=%b sh=%b rs=%b gd=%b pg=%0d, want mv=%b jp=%b jpl=%b sh=%b rs=%b gd=%b pg=%0d",
               name, got.mv, got.jp, got.jpl, got.sh, got.rs, got.gd, got.pg,
               want.mv, want.jp, want.jpl, want.sh, want.rs, want.gd, want.pg);
    end
  endtask

  task automatic do_reset(input string name);
    step(1'b1, 32'h0, o(2'b00, 0, 0, 0, 0, 0, 4'd0), name);
  endtask

  logic [7:0] seq_c[5];
  out_t       z;

  initial begin
    Reset       = 1'b1;
    bus.keycode = '0;
    z           = o(2'b00, 0, 0, 0, 0, 0, 4'd0);
    seq_c       = '{8'h09, 8'h0C, 8'h11, 8'h04, 8'h0F};

    tbl.push_back('{32'h00000000, z});
    tbl.push_back('{32'h00000007, o(2'b01, 0, 0, 0, 0, 0, 4'd0)});
    tbl.push_back('{32'h00000407, o(2'b10, 0, 0, 0, 0, 0, 4'd0)});
    tbl.push_back('{32'h07000004, o(2'b10, 0, 0, 0, 0, 0, 4'd0)});
    tbl.push_back('{32'h00000007, o(2'b01, 0, 0, 0, 0, 0, 4'd0)});
    tbl.push_back('{32'h00000000, z});
    tbl.push_back('{32'h00070400, o(2'b01, 0, 0, 0, 0, 0, 4'd0)});
    tbl.push_back('{32'h00000400, o(2'b10, 0, 0, 0, 0, 0, 4'd0)});
    tbl.push_back('{32'h00000000, z});
    tbl.push_back('{32'h0000001A, o(2'b00, 1, 1, 0, 0, 0, 4'd0)});
    tbl.push_back('{32'h1A000000, o(2'b00, 1, 0, 0, 0, 0, 4'd0)});
    tbl.push_back('{32'h00000000, z});
    tbl.push_back('{32'h00150000, o(2'b00, 0, 0, 0, 1, 0, 4'd0)});
    tbl.push_back('{32'h15001A00, o(2'b00, 1, 1, 0, 1, 0, 4'd0)});
    tbl.push_back('{32'h00000000, z});
    tbl.push_back('{32'h0D000000, o(2'b00, 0, 0, 1, 0, 0, 4'd0)});
    tbl.push_back('{32'h0D000000, z});
    tbl.push_back('{32'h00000000, z});

    do_reset("reset_state");
    for (int i = 0; i < tbl.size(); i++)
      step(1'b0, tbl[i].kc, tbl[i].exp, $sformatf("vec%0d", i));

    // Shoot held 20 cycles: pulses on the 1st, 9th and 17th output cycles, none after release.
    do_reset("reset_shoot");
    for (int i = 0; i < 20; i++)
      step(1'b0, 32'h0000000D, o(2'b00, 0, 0, (i % 8 == 0), 0, 0, 4'd0), $sformatf("shoot%0d", i));
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, z, $sformatf("shoot_rel%0d", i));

    // Full unlock with idle gaps, then clear.
    do_reset("reset_unlock");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, {24'h0, seq_c[i]},
           o((seq_c[i] == 8'h04) ? 2'b10 : 2'b00, 0, 0, 0, 0, (i == 4), (i == 4) ? 4'd0 : 4'(i + 1)),
           $sformatf("unlock_p%0d", i));
      step(1'b0, 32'h0, o(2'b00, 0, 0, 0, 0, (i == 4), (i == 4) ? 4'd0 : 4'(i + 1)),
           $sformatf("unlock_r%0d", i));
    end
    step(1'b0, 32'h00000029, z, "clear_god");

    // Jump key interposed after the third step breaks the sequence.
    do_reset("reset_interpose");
    step(1'b0, 32'h09, o(2'b00, 0, 0, 0, 0, 0, 4'd1), "int_09");
    step(1'b0, 32'h00, o(2'b00, 0, 0, 0, 0, 0, 4'd1), "int_r1");
    step(1'b0, 32'h0C, o(2'b00, 0, 0, 0, 0, 0, 4'd2), "int_0C");
    step(1'b0, 32'h00, o(2'b00, 0, 0, 0, 0, 0, 4'd2), "int_r2");
    step(1'b0, 32'h11, o(2'b00, 0, 0, 0, 0, 0, 4'd3), "int_11");
    step(1'b0, 32'h00, o(2'b00, 0, 0, 0, 0, 0, 4'd3), "int_r3");
    step(1'b0, 32'h1A, o(2'b00, 1, 1, 0, 0, 0, 4'd0), "int_1A");
    step(1'b0, 32'h00, z, "int_r4");
    step(1'b0, 32'h04, o(2'b10, 0, 0, 0, 0, 0, 4'd0), "int_04");
    step(1'b0, 32'h00, z, "int_r5");
    step(1'b0, 32'h0F, z, "int_0F");

    // First code pressed again mid-sequence restarts at step 1.
    do_reset("reset_restart");
    step(1'b0, 32'h09, o(2'b00, 0, 0, 0, 0, 0, 4'd1), "rs_09");
    step(1'b0, 32'h00, o(2'b00, 0, 0, 0, 0, 0, 4'd1), "rs_r1");
    step(1'b0, 32'h0C, o(2'b00, 0, 0, 0, 0, 0, 4'd2), "rs_0C");
    step(1'b0, 32'h00, o(2'b00, 0, 0, 0, 0, 0, 4'd2), "rs_r2");
    step(1'b0, 32'h09, o(2'b00, 0, 0, 0, 0, 0, 4'd1), "rs_09b");

    // Clear in the same report as the final code wins over unlock.
    do_reset("reset_clrpri");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, {24'h0, seq_c[i]},
           o((seq_c[i] == 8'h04) ? 2'b10 : 2'b00, 0, 0, 0, 0, 0, 4'(i + 1)), $sformatf("cp_p%0d", i));
      step(1'b0, 32'h0, o(2'b00, 0, 0, 0, 0, 0, 4'(i + 1)), $sformatf("cp_r%0d", i));
    end
    step(1'b0, 32'h0000290F, z, "clr_pri");
    step(1'b0, 32'h0, z, "clr_pri_hold");

    // Reset while shoot is held at progress 3, then shoot re-fires as a new press.
    do_reset("reset_mid_pre");
    step(1'b0, 32'h0000000D, o(2'b00, 0, 0, 1, 0, 0, 4'd0), "mid_0D");
    step(1'b0, 32'h0000090D, o(2'b00, 0, 0, 0, 0, 0, 4'd1), "mid_09");
    step(1'b0, 32'h0000000D, o(2'b00, 0, 0, 0, 0, 0, 4'd1), "mid_r1");
    step(1'b0, 32'h00000C0D, o(2'b00, 0, 0, 0, 0, 0, 4'd2), "mid_0C");
    step(1'b0, 32'h0000000D, o(2'b00, 0, 0, 0, 0, 0, 4'd2), "mid_r2");
    step(1'b0, 32'h0000110D, o(2'b00, 0, 0, 0, 0, 0, 4'd3), "mid_11");
    step(1'b1, 32'h0000000D, z, "mid_reset");
    step(1'b0, 32'h0000000D, o(2'b00, 0, 0, 1, 0, 0, 4'd0), "mid_after_shoot");
    step(1'b0, 32'h0000000D, z, "mid_after_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
